// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types, defaults and sizing helper for the button conditioner
package button_pkg;

    // Per-channel debounce state
    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } btn_state_t;

    localparam int DEF_N_BUTTONS       = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

    // Counter width: enough bits for the largest cycle count, plus one spare
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-flop synchroniser, debounce FSM, optional auto-repeat (BUTTON_REPEAT_EN)
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_button_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    // The registered outputs update on the same edge as the state change, so the
    // decision is taken one count early: the count that would next become
    // DEBOUNCE_CYCLES-1 is the one that commits the transition.
    localparam logic [CW-1:0] C_ACCEPT = CW'(DEBOUNCE_CYCLES - 2);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CW-1:0] C_DELAY  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] C_PERIOD = CW'(REPEAT_PERIOD - 1);
`endif

    logic          r_sync1;
    logic          r_sync2;
    logic          w_sync;
    btn_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
`ifdef BUTTON_REPEAT_EN
    logic          r_repeating;
`endif

    assign w_sync    = r_sync2;
    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    // Two-flop synchroniser; idles released (high) out of reset
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_button_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM with stability counter and registered level/pulse outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= RELEASED;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            r_repeating <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (!w_sync) begin
                        r_state <= PRESS_PENDING;
                        r_cnt   <= '0;
                    end
                end
                PRESS_PENDING: begin
                    if (w_sync) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_ACCEPT) begin
                        r_state     <= PRESSED;
                        r_cnt       <= '0;
                        r_level     <= 1'b1;
                        r_press     <= 1'b1;
`ifdef BUTTON_REPEAT_EN
                        r_repeating <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_sync) begin
                        r_state <= RELEASE_PENDING;
                        r_cnt   <= '0;
`ifdef BUTTON_REPEAT_EN
                    end else if (!r_repeating && r_cnt == C_DELAY) begin
                        r_press     <= 1'b1;
                        r_cnt       <= '0;
                        r_repeating <= 1'b1;
                    end else if (r_repeating && r_cnt == C_PERIOD) begin
                        r_press <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                RELEASE_PENDING: begin
                    if (!w_sync) begin
                        // Bounce back: repeat timing starts over from the delay
                        r_state     <= PRESSED;
                        r_cnt       <= '0;
`ifdef BUTTON_REPEAT_EN
                        r_repeating <= 1'b0;
`endif
                    end else if (r_cnt == C_ACCEPT) begin
                        r_state   <= RELEASED;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N independent debounced buttons; auto-repeat enabled by BUTTON_REPEAT_EN
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = DEF_N_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [N_BUTTONS-1:0] i_button_n,
    output logic [N_BUTTONS-1:0] o_level,
    output logic [N_BUTTONS-1:0] o_press,
    output logic [N_BUTTONS-1:0] o_release
);

    // One fully independent channel per button pin
    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clock    (i_clock),
            .i_reset_n  (i_reset_n),
            .i_button_n (i_button_n[g]),
            .o_level    (o_level[g]),
            .o_press    (o_press[g]),
            .o_release  (o_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner; repeat checks under BUTTON_REPEAT_EN
module tb_button_conditioner;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    typedef struct {
        logic [2:0] btn_n;
        int         hold;
        logic [2:0] pr;
        logic [2:0] rl;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [2:0] pr;
        logic [2:0] rl;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] level, press, rel;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   in_reset = 1'b1;
    logic [2:0] exp_level = 3'b000;
    ev_t  sb[$];
    vec_t vec[11];

    button_conditioner #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (reset_n),
        .i_button_n (btn_n),
        .o_level    (level),
        .o_press    (press),
        .o_release  (rel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: collect events due now, update expected level, compare all outputs
    always @(negedge clk) begin
        logic [2:0] epr;
        logic [2:0] erl;
        if (!in_reset) begin
            epr = 3'b000;
            erl = 3'b000;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    epr |= sb[i].pr;
                    erl |= sb[i].rl;
                    sb.delete(i);
                end
            end
            exp_level = (exp_level | epr) & ~erl;
            n_checks++;
            if ({level, press, rel} !== {exp_level, epr, erl}) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: level/press/release got %b/%b/%b want %b/%b/%b",
                         cyc, level, press, rel, exp_level, epr, erl);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Input driven while cyc == c is captured at edge c+1; outputs follow D+1 edges later
    task automatic push_press(input int c, input logic [2:0] m, input int hold);
        int t;
        sb.push_back('{cyc: c + D + 2, pr: m, rl: 3'b000});
`ifdef BUTTON_REPEAT_EN
        t = c + D + 2 + RD;
        while (t < c + hold + 3) begin
            sb.push_back('{cyc: t, pr: m, rl: 3'b000});
            t += RP;
        end
`else
        t = hold;
`endif
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({level, press, rel} !== 9'b0) begin
            n_fail++;
            $display("FAIL %s: level/press/release got %b/%b/%b want 000/000/000", name, level, press, rel);
        end
    endtask

    initial begin
        int c;

        vec[0]  = '{btn_n: 3'b111, hold: 8,  pr: 3'b000, rl: 3'b000};
        vec[1]  = '{btn_n: 3'b110, hold: 10, pr: 3'b001, rl: 3'b000};
        vec[2]  = '{btn_n: 3'b111, hold: 10, pr: 3'b000, rl: 3'b001};
        vec[3]  = '{btn_n: 3'b101, hold: 3,  pr: 3'b000, rl: 3'b000};
        vec[4]  = '{btn_n: 3'b111, hold: 1,  pr: 3'b000, rl: 3'b000};
        vec[5]  = '{btn_n: 3'b101, hold: 3,  pr: 3'b000, rl: 3'b000};
        vec[6]  = '{btn_n: 3'b111, hold: 10, pr: 3'b000, rl: 3'b000};
        vec[7]  = '{btn_n: 3'b000, hold: 10, pr: 3'b111, rl: 3'b000};
        vec[8]  = '{btn_n: 3'b111, hold: 10, pr: 3'b000, rl: 3'b111};
        vec[9]  = '{btn_n: 3'b011, hold: 25, pr: 3'b100, rl: 3'b000};
        vec[10] = '{btn_n: 3'b111, hold: 10, pr: 3'b000, rl: 3'b100};

        // Power-on reset
        #2;
        check_zero("reset_state");
        wait_cycles(3);
        #1 reset_n = 1'b1;
        in_reset = 1'b0;
        wait_cycles(1);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            c = cyc;
            btn_n = vec[i].btn_n;
            if (vec[i].pr != 3'b000) push_press(c, vec[i].pr, vec[i].hold);
            if (vec[i].rl != 3'b000) sb.push_back('{cyc: c + D + 2, pr: 3'b000, rl: vec[i].rl});
            wait_cycles(vec[i].hold);
        end

        // Reset mid-pending: ch1 already pressed, ch0 two cycles into its press
        c = cyc;
        btn_n = 3'b101;
        sb.push_back('{cyc: c + D + 2, pr: 3'b010, rl: 3'b000});
        wait_cycles(7);
        btn_n = 3'b100;
        wait_cycles(2);
        #1 reset_n = 1'b0;
        in_reset = 1'b1;
        sb.delete();
        exp_level = 3'b000;
        #1 check_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        in_reset = 1'b0;
        c = cyc;
        sb.push_back('{cyc: c + D + 2, pr: 3'b011, rl: 3'b000});
        wait_cycles(7);
        c = cyc;
        btn_n = 3'b111;
        sb.push_back('{cyc: c + D + 2, pr: 3'b000, rl: 3'b011});
        wait_cycles(12);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending events got %0d want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
